// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
// Adds two WORDS*16-bit operands one 16-bit chunk per cycle, least-significant
// chunk first, through a single combinational 16-bit carry-lookahead adder.
// The carry between chunks is held in a register.
// Optional feature macro: MP_SUB_EN adds the `sub` port. When `sub` is set,
// the block computes A-B as A + ~B + 1.
//
// Handshake: `start` is sampled only while idle or in the DONE cycle. An
// accepted start raises `busy` for exactly WORDS cycles. After that, `done`
// pulses for one cycle, and `sum`/`cout`/`ovf` are valid from that cycle on.
// `start` seen during `busy` is ignored. `start` held in the DONE cycle
// launches the next operation with no idle gap.

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    // Two-level lookahead: 4-bit group generate/propagate, then group carries,
    // then bit carries inside each group from that group's carry-in.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '1;
        gc = '0;
        c  = '0;
        for (int grp = 0; grp < 4; grp++) begin
            for (int i = 0; i < 4; i++) begin
                gg[grp] = g[4*grp+i] | (p[4*grp+i] & gg[grp]);
                gp[grp] = gp[grp] & p[4*grp+i];
            end
        end
        gc[0] = ci;
        for (int grp = 0; grp < 4; grp++) begin
            gc[grp+1] = gg[grp] | (gp[grp] & gc[grp]);
        end
        for (int grp = 0; grp < 4; grp++) begin
            c[4*grp] = gc[grp];
            for (int i = 0; i < 3; i++) begin
                c[4*grp+i+1] = g[4*grp+i] | (p[4*grp+i] & c[4*grp+i]);
            end
        end
        s  = p ^ c;
        co = gc[4];
    end
endmodule

module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  cin,
`ifdef MP_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);
    localparam int          W    = 16 * WORDS;
    localparam logic [2:0]  LAST = 3'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           carry;
    logic [2:0]     idx;

    logic [W-1:0]   b_load;
    logic           c_load;
    logic [15:0]    a_ch;
    logic [15:0]    b_ch;
    logic [15:0]    core_sum;
    logic           core_cout;
    logic           c15;

    // Operand-B and initial-carry selection at start; subtract is A + ~B + 1.
`ifdef MP_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    // Chunk mux: select the 16-bit slice of each operand addressed by idx.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx == 3'(k)) begin
                a_ch = opa[16*k +: 16];
                b_ch = opb[16*k +: 16];
            end
        end
    end

    cla16 u_cla (
        .a  (a_ch),
        .b  (b_ch),
        .ci (carry),
        .s  (core_sum),
        .co (core_cout)
    );

    // Carry into the top bit of the current chunk; used only on the last one.
    assign c15 = a_ch[15] ^ b_ch[15] ^ core_sum[15];

    // Sequencer: latch operands on start, process one chunk per RUN cycle,
    // and capture flags on the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_load;
                        carry <= c_load;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx == 3'(k)) begin
                            sum[16*k +: 16] <= core_sum;
                        end
                    end
                    carry <= core_cout;
                    if (idx == LAST) begin
                        cout  <= core_cout;
                        ovf   <= core_cout ^ c15;
                        state <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status decoded straight from the state register.
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed testbench for mp_add_seq with WORDS=4 and hand-computed results.
// Subtract vectors run only when MP_SUB_EN is defined.

module tb_mp_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           cin_in;
`ifdef MP_SUB_EN
    logic           sub_in;
`endif
    logic           busy;
    logic           done;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int bcnt;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin_in),
`ifdef MP_SUB_EN
        .sub       (sub_in),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Driver: present operands with start for one rising edge (E0).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done, bounded. lat counts edges from E0 inclusive; bcnt counts
    // busy cycles. With glitch set, a start with different operands is pulsed
    // mid-RUN.
    task automatic wait_done(input bit glitch, output int lat_o, output int bcnt_o);
        bit seen;
        seen   = 1'b0;
        lat_o  = 1;
        bcnt_o = 0;
        while (!seen && lat_o < 20) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bcnt_o++;
                lat_o++;
                if (glitch && lat_o == 3) begin
                    start  = 1'b1;
                    a_in   = ~a_in;
                    b_in   = ~b_in;
                    cin_in = ~cin_in;
                end
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout: got no done after %0d edges, expected done", lat_o);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
`ifdef MP_SUB_EN
        sub_in = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ripple across chunks
        launch(64'h0001_0000_FFFF_FFFF, 64'h1, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check("ripple_lat", lat, 5);
        check("ripple_busy", bcnt, 4);
        check("ripple_sum", sum, 64'h0001_0001_0000_0000);
        check("ripple_cout", cout, 0);
        check("ripple_ovf", ovf, 0);
        check("ripple_state", dbg_state, 2);
        @(negedge clk);

        // All ones plus carry-in
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_done(1'b0, lat, bcnt);
        check("ones_sum", sum, 64'h0);
        check("ones_cout", cout, 1);
        check("ones_ovf", ovf, 0);
        @(negedge clk);

        // Signed overflow
        launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check("ovf_sum", sum, 64'h8000_0000_0000_0000);
        check("ovf_cout", cout, 0);
        check("ovf_ovf", ovf, 1);
        @(negedge clk);

        // Start pulse during RUN is ignored
        launch(64'h3, 64'h4, 1'b0);
        wait_done(1'b1, lat, bcnt);
        check("glitch_lat", lat, 5);
        check("glitch_busy", bcnt, 4);
        check("glitch_sum", sum, 64'h7);
        check("glitch_cout", cout, 0);
        @(negedge clk);
        check("glitch_idle", dbg_state, 0);

        // Back-to-back: second start held in the DONE cycle
        launch(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check("b2b1_sum", sum, 64'h2222_3333_4444_5555);
        launch(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        wait_done(1'b0, lat, bcnt);
        check("b2b2_lat", lat, 5);
        check("b2b2_busy", bcnt, 4);
        check("b2b2_sum", sum, 64'h1);
        check("b2b2_cout", cout, 1);
        check("b2b2_ovf", ovf, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

`ifdef MP_SUB_EN
        // Subtract; cin is ignored
        sub_in = 1'b1;
        launch(64'h5, 64'h7, 1'b1);
        wait_done(1'b0, lat, bcnt);
        check("sub57_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub57_cout", cout, 0);
        check("sub57_ovf", ovf, 0);
        @(negedge clk);
        launch(64'h7, 64'h5, 1'b1);
        wait_done(1'b0, lat, bcnt);
        check("sub75_sum", sum, 64'h2);
        check("sub75_cout", cout, 1);
        check("sub75_ovf", ovf, 0);
        sub_in = 1'b0;
        @(negedge clk);
`endif

        // Asynchronous reset in the third RUN cycle
        launch(64'h1234_5678_9ABC_DEF0, 64'h0101_0101_0101_0101, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_sum_lo", {32'h0, sum[31:0]}, 64'h9BBD_DFF1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        check("arst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(64'h1, 64'h1, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check("post_lat", lat, 5);
        check("post_sum", sum, 64'h2);
        check("post_cout", cout, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
